// File: rtl/display_arbiter.sv
// display_arbiter
//   Shares the 4-digit 7-segment display between two producers. Each producer
//   offers a 16-bit BCD word {thousands,hundreds,tens,units}. The arbiter
//   grants round-robin and latches the granted word into D3..D0. It then keeps
//   that owner for at least HOLD_CYCLES cycles, so the digits never flicker
//   between sources.
//
// Handshake: a word moves when VALIDx && READYx are both high at a posedge of
//   CLK. READYx is combinational from the arbiter state and from the VALID
//   inputs. It never depends on DATAx. A requester that sees READY=0 keeps
//   VALID and DATA stable until it is accepted.
//
// Ports
//   CLK            in   1   system clock, posedge
//   RST_N          in   1   asynchronous active-low reset
//   VALID0/DATA0   in   1/16 requester 0 offer
//   READY0         out  1   requester 0 accepted this cycle
//   VALID1/DATA1   in   1/16 requester 1 offer
//   READY1         out  1   requester 1 accepted this cycle
//   D0..D3         out  4   registered digit nibbles (D0 = units)
//   OWNER          out  1   requester whose value is shown
//   BUSY           out  1   high while the hold period runs
//   dbg_state      out  1   FSM state (0 = IDLE, 1 = HOLD)
module display_arbiter #(
    parameter int HOLD_W      = 16,
    parameter int HOLD_CYCLES = 50000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        VALID0,
    input  logic [15:0] DATA0,
    output logic        READY0,
    input  logic        VALID1,
    input  logic [15:0] DATA1,
    output logic        READY1,
    output logic [3:0]  D0,
    output logic [3:0]  D1,
    output logic [3:0]  D2,
    output logic [3:0]  D3,
    output logic        OWNER,
    output logic        BUSY,
    output logic [0:0]  dbg_state
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // The counter is loaded with HOLD_CYCLES-1 and runs down to 0 inclusive.
    // That gives exactly HOLD_CYCLES cycles of ownership.
    localparam logic [HOLD_W-1:0] RELOAD = HOLD_W'(HOLD_CYCLES - 1);

    logic [0:0]        state;
    logic              rr;        // side preferred when both requesters are valid
    logic [HOLD_W-1:0] count;

    logic              grant_any;
    logic              grant_sel;
    logic              xfer0;
    logic              xfer1;
    logic              xfer;
    logic [15:0]       xfer_data;

    // IDLE grant: the sole valid requester wins. When both are valid, the
    // rr pointer decides.
    always_comb begin
        grant_any = VALID0 | VALID1;
        grant_sel = 1'b0;
        if (VALID0 && VALID1) begin
            grant_sel = rr;
        end else if (VALID1) begin
            grant_sel = 1'b1;
        end
    end

    // READY is gated by RST_N so that no handshake completes while reset is
    // asserted. In HOLD, only the owner may refresh its value.
    always_comb begin
        READY0 = 1'b0;
        READY1 = 1'b0;
        if (RST_N) begin
            if (state == ST_IDLE) begin
                if (grant_any) begin
                    READY0 = ~grant_sel;
                    READY1 = grant_sel;
                end
            end else begin
                READY0 = ~OWNER;
                READY1 = OWNER;
            end
        end
    end

    assign xfer0     = VALID0 & READY0;
    assign xfer1     = VALID1 & READY1;
    assign xfer      = xfer0 | xfer1;
    assign xfer_data = xfer1 ? DATA1 : DATA0;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
            rr    <= 1'b0;
            count <= '0;
            OWNER <= 1'b0;
            D0    <= 4'h0;
            D1    <= 4'h0;
            D2    <= 4'h0;
            D3    <= 4'h0;
        end else if (state == ST_IDLE) begin
            if (xfer) begin
                {D3, D2, D1, D0} <= xfer_data;
                OWNER            <= xfer1;
                rr               <= ~xfer1;    // next contested grant goes to the other side
                count            <= RELOAD;
                state            <= ST_HOLD;
            end
        end else begin
            // In HOLD only the owner can transfer. A refresh on the
            // counter==0 cycle still reloads the counter, so the owner keeps
            // the display.
            if (xfer) begin
                {D3, D2, D1, D0} <= xfer_data;
                count            <= RELOAD;
            end else if (count != '0) begin
                count <= count - 1'b1;
            end else begin
                state <= ST_IDLE;
            end
        end
    end

    assign BUSY      = (state == ST_HOLD);
    assign dbg_state = state;

endmodule
